// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: func codes and FSM states.
// The execute-stage decoder imports the same func encodings.
package muldiv_pkg;

    typedef enum logic [2:0] {
        FUNC_MUL    = 3'd0,
        FUNC_MULH   = 3'd1,
        FUNC_MULHSU = 3'd2,
        FUNC_MULHU  = 3'd3,
        FUNC_DIV    = 3'd4,
        FUNC_DIVU   = 3'd5,
        FUNC_REM    = 3'd6,
        FUNC_REMU   = 3'd7
    } func_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic func_is_mul(input func_t f);
        return f inside {FUNC_MUL, FUNC_MULH, FUNC_MULHSU, FUNC_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage (master) and muldiv_unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             in_valid;
    logic             in_ready;
    func_t            func;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             kill;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;

    modport master (
        output in_valid, func, in1, in2, kill, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, func, in1, in2, kill, out_ready,
        output in_ready, out_valid, out
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and shift the resulting quotient bit in.
module div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_in < divisor, so shifted < 2*divisor and a clear top bit of trial means it fits.
    always_comb begin
        shifted = {rem_in, quot_in[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_out  = trial[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out  = shifted[WIDTH-1:0];
            quot_out = {quot_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: iterative shift-add multiplier, restoring divider.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiplier with one combinational multiply.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int MUL_STEP_BITS = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] MUL_ITERS = CW'(WIDTH / MUL_STEP_BITS);
    localparam logic [CW-1:0] DIV_ITERS = CW'(WIDTH);

    state_t              state;
    logic [CW-1:0]       cnt;

    logic [2*WIDTH-1:0]  acc_q;
    logic [2*WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [WIDTH-1:0]    in1_q;
    logic                mul_hi_q;
    logic                mul_corr_q;

    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    quot_q;
    logic [WIDTH-1:0]    dvsr_q;
    logic                rem_sel_q;
    logic                neg_quot_q;
    logic                neg_rem_q;

    logic                is_mul;
    logic                a_signed;
    logic                b_signed;
    logic [2*WIDTH-1:0]  a_ext;
    logic                div_signed;
    logic                is_rem;
    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic                div_zero;
    logic                div_ovf;

    logic [2*WIDTH-1:0]  acc_step;
    logic [2*WIDTH-1:0]  mul_full;
    logic [WIDTH-1:0]    div_res;
    logic [WIDTH-1:0]    rem_nx;
    logic [WIDTH-1:0]    quot_nx;

    // Request decode, evaluated against the operands presented in IDLE.
    always_comb begin
        is_mul     = func_is_mul(bus.func);
        a_signed   = bus.func inside {FUNC_MULH, FUNC_MULHSU};
        b_signed   = (bus.func == FUNC_MULH);
        a_ext      = a_signed ? {{WIDTH{bus.in1[WIDTH-1]}}, bus.in1} : {{WIDTH{1'b0}}, bus.in1};
        div_signed = bus.func inside {FUNC_DIV, FUNC_REM};
        is_rem     = bus.func inside {FUNC_REM, FUNC_REMU};
        a_neg      = div_signed && ($signed(bus.in1) < 0);
        b_neg      = div_signed && ($signed(bus.in2) < 0);
        a_mag      = a_neg ? -bus.in1 : bus.in1;
        b_mag      = b_neg ? -bus.in2 : bus.in2;
        div_zero   = (bus.in2 == '0);
        div_ovf    = div_signed && (bus.in1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.in2 == '1);
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] fast_prod;
    assign b_ext     = b_signed ? {{WIDTH{bus.in2[WIDTH-1]}}, bus.in2} : {{WIDTH{1'b0}}, bus.in2};
    assign fast_prod = a_ext * b_ext;
`endif

    // Retire MUL_STEP_BITS multiplier bits per cycle into the 2*WIDTH accumulator.
    always_comb begin
        acc_step = acc_q;
        for (int j = 0; j < MUL_STEP_BITS; j++) begin
            if (mplier_q[j]) begin
                acc_step = acc_step + (mcand_q << j);
            end
        end
    end

    // Only WIDTH multiplier bits are iterated; a signed rs2 with its MSB set
    // contributes -2^WIDTH * rs1, which reduces to subtracting rs1 from the high half.
    always_comb begin
        mul_full = acc_q - (mul_corr_q ? {in1_q, {WIDTH{1'b0}}} : {(2*WIDTH){1'b0}});
        if (rem_sel_q) begin
            div_res = neg_rem_q ? -rem_q : rem_q;
        end else begin
            div_res = neg_quot_q ? -quot_q : quot_q;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in   (rem_q),
        .quot_in  (quot_q),
        .divisor  (dvsr_q),
        .rem_out  (rem_nx),
        .quot_out (quot_nx)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
        end else if (bus.kill) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        in1_q        <= bus.in1;
                        if (is_mul) begin
                            state    <= ST_MUL;
                            mul_hi_q <= (bus.func != FUNC_MUL);
                            mcand_q  <= a_ext;
                            mplier_q <= bus.in2;
`ifdef MULDIV_FAST_MUL_EN
                            acc_q      <= fast_prod;
                            mul_corr_q <= 1'b0;
                            cnt        <= '0;
`else
                            acc_q      <= '0;
                            mul_corr_q <= b_signed & bus.in2[WIDTH-1];
                            cnt        <= MUL_ITERS;
`endif
                        end else begin
                            // Special cases preload the final quotient/remainder and skip iteration.
                            state     <= ST_DIV;
                            rem_sel_q <= is_rem;
                            dvsr_q    <= b_mag;
                            if (div_zero) begin
                                quot_q     <= '1;
                                rem_q      <= bus.in1;
                                neg_quot_q <= 1'b0;
                                neg_rem_q  <= 1'b0;
                                cnt        <= '0;
                            end else if (div_ovf) begin
                                quot_q     <= bus.in1;
                                rem_q      <= '0;
                                neg_quot_q <= 1'b0;
                                neg_rem_q  <= 1'b0;
                                cnt        <= '0;
                            end else begin
                                quot_q     <= a_mag;
                                rem_q      <= '0;
                                neg_quot_q <= a_neg ^ b_neg;
                                neg_rem_q  <= a_neg;
                                cnt        <= DIV_ITERS;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt != '0) begin
                        acc_q    <= acc_step;
                        mcand_q  <= mcand_q << MUL_STEP_BITS;
                        mplier_q <= mplier_q >> MUL_STEP_BITS;
                        cnt      <= cnt - 1'b1;
                    end else begin
                        bus.out       <= mul_hi_q ? mul_full[2*WIDTH-1:WIDTH] : mul_full[WIDTH-1:0];
                        bus.out_valid <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (cnt != '0) begin
                        rem_q  <= rem_nx;
                        quot_q <= quot_nx;
                        cnt    <= cnt - 1'b1;
                    end else begin
                        bus.out       <= div_res;
                        bus.out_valid <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32); latency expectations follow MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .MUL_STEP_BITS(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, wait (bounded) for the result, check latency and value, then hand off.
    task automatic run_op(input string tag, input func_t f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
        int lat;
        check_eq({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.func      = f;
        bus.in1       = a;
        bus.in2       = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.out_valid && lat < 100);
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " out"}, bus.out, exp);
        tick();
        check_eq({tag, " handoff"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rises;
        bus.in_valid  = 1'b0;
        bus.func      = FUNC_MUL;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check_eq("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset out", bus.out, 32'h0);

        run_op("MUL 7*-3",       FUNC_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("MULH 7*-3",      FUNC_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT);
        run_op("MULHU 7*fffd",   FUNC_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, MUL_LAT);
        run_op("MUL ff*ff",      FUNC_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);
        run_op("MULH -1*-1",     FUNC_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_op("MULHSU -1*ff",   FUNC_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("MULHU ff*ff",    FUNC_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);

        run_op("DIV -7/2",       FUNC_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT);
        run_op("REM -7/2",       FUNC_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
        run_op("DIV 7/-2",       FUNC_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
        run_op("REM 7/-2",       FUNC_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
        run_op("DIVU 100/7",     FUNC_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT);
        run_op("REMU 100/7",     FUNC_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT);
        run_op("DIVU ffff/1",    FUNC_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, DIV_LAT);

        run_op("DIVU 5/0",       FUNC_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, SPC_LAT);
        run_op("REMU 5/0",       FUNC_REMU,   32'd5,         32'd0,         32'd5,         SPC_LAT);
        run_op("REM -7/0",       FUNC_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPC_LAT);
        run_op("DIV ovf",        FUNC_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        run_op("REM ovf",        FUNC_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);

        // Consumer back-pressure: result must hold while out_ready is low.
        bus.func      = FUNC_DIVU;
        bus.in1       = 32'd100;
        bus.in2       = 32'd7;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.out_valid && lat < 100);
        check_eq("hold latency", 32'(lat), 32'(DIV_LAT));
        for (int i = 0; i < 5; i++) begin
            check_eq("hold out", bus.out, 32'd14);
            check_eq("hold out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("hold in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check_eq("release out_valid", 32'(bus.out_valid), 32'd0);
        run_op("after hold MUL", FUNC_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);

        // kill dominates a simultaneous accept.
        bus.func     = FUNC_DIVU;
        bus.in1      = 32'd5;
        bus.in2      = 32'd0;
        bus.in_valid = 1'b1;
        bus.kill     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.kill     = 1'b0;
        check_eq("kill accept in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check_eq("kill accept out_valid", 32'(bus.out_valid), 32'd0);

        // kill during the 10th divide iteration.
        bus.func     = FUNC_DIV;
        bus.in1      = 32'd100;
        bus.in2      = 32'd7;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        check_eq("kill in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("kill out_valid", 32'(bus.out_valid), 32'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) rises++;
        end
        check_eq("kill no result", 32'(rises), 32'd0);
        run_op("after kill MULHU", FUNC_MULHU, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, MUL_LAT);

        // Reset pulse in the middle of a divide.
        bus.func     = FUNC_DIV;
        bus.in1      = 32'hFFFF_FFF9;
        bus.in2      = 32'd2;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midreset out", bus.out, 32'h0);
        check_eq("midreset in_ready", 32'(bus.in_ready), 32'd1);
        run_op("after reset REM", FUNC_REM, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
